// File: rtl/game_regs_pkg.sv
// Shared game register-map definitions: sizes, word offsets, position layout, cure FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_regs_pkg;

  localparam int TANK_NUM    = 2;
  localparam int COIN_NUM    = 3;
  localparam int WALL_NUM    = 16;
  localparam int BULLET_NUM  = 4;
  localparam int INIT_HEALTH = 5;

  // Word offsets relative to the block base address.
  localparam int OFF_CTRL      = 0;
  localparam int OFF_GAME_ATTR = 1;
  localparam int OFF_COIN      = 2;
  localparam int OFF_CURE      = 5;
  localparam int OFF_INIT_POS  = 7;
  localparam int OFF_WALL      = 9;
  localparam int OFF_STATUS    = 25;
  localparam int REG_NUM       = 26;

  // Position word: bit0 valid, [10:1] x, [20:11] y; same layout as the tank feedback regs.
  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
    logic       valid;
  } pos_t;

  typedef enum logic [1:0] {
    CURE_IDLE,
    CURE_REQ,
    CURE_RELEASE
  } cure_state_t;

  localparam pos_t INIT_POS_VAL = '{y: 10'd0, x: 10'd0, valid: 1'b1};

  function automatic logic [31:0] pos_word(input pos_t p);
    return {11'b0, p};
  endfunction

  // Merge a write into an existing word, one byte lane per byte-enable bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_dat,
                                           input logic [31:0] wr_dat,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wr_dat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/game_config_regs_if.sv
// Avalon-MM slave bus carrying NIOS accesses into the game config block.
// Latency: read data valid one clock after the read strobe.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
interface game_config_regs_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [11:0] AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/cure_handshake.sv
// Per-tank cure request: raises to_cure until one cured ack, then waits for the ack to drop.
// Latency: to_cure rises the clock after req_set (if health not full), falls the clock after cured.
// Backpressure: req_set while busy is dropped; each request retires on exactly one ack.
module cure_handshake
  import game_regs_pkg::*;
#(
  parameter int MAX_HEALTH = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_set,
  input  logic [31:0] health_in,
  input  logic        cured,
  output logic        to_cure,
  output logic        busy
);

  cure_state_t state, state_nxt;
  logic        cure_pend, cure_pend_nxt;
  logic        health_low;

  assign health_low = (health_in < 32'(MAX_HEALTH));

  // State and sticky request flag; reset abandons any partial handshake.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= CURE_IDLE;
      cure_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cure_pend <= cure_pend_nxt;
    end
  end

  // Next-state and request output; a new request is only seen in IDLE.
  always_comb begin
    state_nxt     = state;
    cure_pend_nxt = cure_pend;
    to_cure       = 1'b0;
    unique case (state)
      CURE_IDLE: begin
        if (cure_pend || req_set) begin
          if (health_low) begin
            state_nxt     = CURE_REQ;
            cure_pend_nxt = 1'b1;
          end else begin
            cure_pend_nxt = 1'b0;
          end
        end
      end
      CURE_REQ: begin
        to_cure = 1'b1;
        if (cured) begin
          state_nxt     = CURE_RELEASE;
          cure_pend_nxt = 1'b0;
        end
      end
      CURE_RELEASE: begin
        if (!cured) state_nxt = CURE_IDLE;
      end
      default: begin
        state_nxt     = CURE_IDLE;
        cure_pend_nxt = 1'b0;
      end
    endcase
  end

  assign busy = cure_pend || (state != CURE_IDLE);

endmodule

// File: rtl/game_config_regs.sv
// Game config register map: shadow regs written by NIOS, copied to live outputs on armed frame tick.
// Latency: read data one clock after read strobe; live config updates in the tick clock after commit.
// Backpressure: none; every Avalon access completes immediately, unmapped accesses are ignored.
module game_config_regs
  import game_regs_pkg::*;
#(
  parameter int BASE_ADDR  = 2055,
  parameter int MAX_HEALTH = 5
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  game_config_regs_if.slave   avl,
  input  logic [31:0]         health_in [TANK_NUM],
  input  logic                cured,
  output logic [TANK_NUM-1:0] to_cure,
  output logic                game_run,
  output logic [31:0]         game_attr,
  output logic [31:0]         coin_attr [COIN_NUM],
  output logic [31:0]         init_pos  [TANK_NUM],
  output logic [31:0]         wall_pos  [WALL_NUM]
);

  localparam logic [11:0] BASE = 12'(BASE_ADDR);

  logic [11:0] off;
  logic        in_range;
  logic        wr_en;
  logic        commit_set;
  logic        commit_pending;

  logic        run_sh;
  logic [31:0] game_sh;
  logic [31:0] coin_sh [COIN_NUM];
  logic [31:0] init_sh [TANK_NUM];
  logic [31:0] wall_sh [WALL_NUM];

  logic [TANK_NUM-1:0] cure_wr;
  logic [TANK_NUM-1:0] cure_busy;
  logic [31:0]         rd_mux;

  assign off      = avl.AVL_ADDR - BASE;
  assign in_range = (avl.AVL_ADDR >= BASE) && (off < 12'(REG_NUM));
  assign wr_en    = avl.AVL_CS && avl.AVL_WRITE && in_range;

  // Commit and cure strobes need byte lane 0, which holds their trigger bit.
  assign commit_set = wr_en && (off == 12'(OFF_CTRL)) && avl.AVL_BYTE_EN[0] && avl.AVL_WRITEDATA[1];

  always_comb begin
    for (int k = 0; k < TANK_NUM; k++) begin
      cure_wr[k] = wr_en && (off == 12'(OFF_CURE + k)) &&
                   avl.AVL_BYTE_EN[0] && avl.AVL_WRITEDATA[0];
    end
  end

  // Shadow registers: byte-lane writes from software, never seen by the game until a commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_sh  <= 1'b0;
      game_sh <= '0;
      for (int i = 0; i < COIN_NUM; i++) coin_sh[i] <= '0;
      for (int i = 0; i < TANK_NUM; i++) init_sh[i] <= pos_word(INIT_POS_VAL);
      for (int i = 0; i < WALL_NUM; i++) wall_sh[i] <= '0;
    end else if (wr_en) begin
      if ((off == 12'(OFF_CTRL)) && avl.AVL_BYTE_EN[0]) run_sh <= avl.AVL_WRITEDATA[0];
      if (off == 12'(OFF_GAME_ATTR))
        game_sh <= apply_be(game_sh, avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
      for (int i = 0; i < COIN_NUM; i++)
        if (off == 12'(OFF_COIN + i))
          coin_sh[i] <= apply_be(coin_sh[i], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
      for (int i = 0; i < TANK_NUM; i++)
        if (off == 12'(OFF_INIT_POS + i))
          init_sh[i] <= apply_be(init_sh[i], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
      for (int i = 0; i < WALL_NUM; i++)
        if (off == 12'(OFF_WALL + i))
          wall_sh[i] <= apply_be(wall_sh[i], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
    end
  end

  // Commit arm: consumed by a tick only if armed before it; a write in that same clock re-arms.
  always_ff @(posedge Clk) begin
    if (Reset) commit_pending <= 1'b0;
    else       commit_pending <= commit_set || (commit_pending && !frame_tick);
  end

  // Live config: whole-map copy at an armed tick, sampling shadow values from before this clock's write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_run  <= 1'b0;
      game_attr <= '0;
      for (int i = 0; i < COIN_NUM; i++) coin_attr[i] <= '0;
      for (int i = 0; i < TANK_NUM; i++) init_pos[i]  <= pos_word(INIT_POS_VAL);
      for (int i = 0; i < WALL_NUM; i++) wall_pos[i]  <= '0;
    end else if (frame_tick && commit_pending) begin
      game_run  <= run_sh;
      game_attr <= game_sh;
      for (int i = 0; i < COIN_NUM; i++) coin_attr[i] <= coin_sh[i];
      for (int i = 0; i < TANK_NUM; i++) init_pos[i]  <= init_sh[i];
      for (int i = 0; i < WALL_NUM; i++) wall_pos[i]  <= wall_sh[i];
    end
  end

  // Read mux over shadow state; CURE words report that tank's handshake as busy.
  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      if (off == 12'(OFF_CTRL))      rd_mux = {31'b0, run_sh};
      if (off == 12'(OFF_GAME_ATTR)) rd_mux = game_sh;
      for (int i = 0; i < COIN_NUM; i++)
        if (off == 12'(OFF_COIN + i)) rd_mux = coin_sh[i];
      for (int i = 0; i < TANK_NUM; i++)
        if (off == 12'(OFF_CURE + i)) rd_mux = {31'b0, cure_busy[i]};
      for (int i = 0; i < TANK_NUM; i++)
        if (off == 12'(OFF_INIT_POS + i)) rd_mux = init_sh[i];
      for (int i = 0; i < WALL_NUM; i++)
        if (off == 12'(OFF_WALL + i)) rd_mux = wall_sh[i];
      if (off == 12'(OFF_STATUS))    rd_mux = {30'b0, |cure_busy, commit_pending};
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge Clk) begin
    if (Reset)                           avl.AVL_READDATA <= '0;
    else if (avl.AVL_CS && avl.AVL_READ) avl.AVL_READDATA <= rd_mux;
  end

  for (genvar k = 0; k < TANK_NUM; k++) begin : g_cure
    cure_handshake #(.MAX_HEALTH(MAX_HEALTH)) u_cure (
      .Clk       (Clk),
      .Reset     (Reset),
      .req_set   (cure_wr[k]),
      .health_in (health_in[k]),
      .cured     (cured),
      .to_cure   (to_cure[k]),
      .busy      (cure_busy[k])
    );
  end

endmodule

// File: tb/tb_game_config_regs.sv
// Directed bench for game_config_regs: map reads, commit timing, cure handshake, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_config_regs;
  import game_regs_pkg::*;

  localparam int BASE = 2055;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                frame_tick;
  logic [31:0]         health_in [TANK_NUM];
  logic                cured;
  logic [TANK_NUM-1:0] to_cure;
  logic                game_run;
  logic [31:0]         game_attr;
  logic [31:0]         coin_attr [COIN_NUM];
  logic [31:0]         init_pos  [TANK_NUM];
  logic [31:0]         wall_pos  [WALL_NUM];

  int checks = 0;
  int errors = 0;

  game_config_regs_if avl ();

  game_config_regs #(.BASE_ADDR(BASE), .MAX_HEALTH(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .avl        (avl.slave),
    .health_in  (health_in),
    .cured      (cured),
    .to_cure    (to_cure),
    .game_run   (game_run),
    .game_attr  (game_attr),
    .coin_attr  (coin_attr),
    .init_pos   (init_pos),
    .wall_pos   (wall_pos)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one write for one clock, starting and ending on a falling edge.
  task automatic avl_write(input int addr, input logic [31:0] dat, input logic [3:0] be);
    @(negedge Clk);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1;
    avl.AVL_ADDR = 12'(addr); avl.AVL_WRITEDATA = dat; avl.AVL_BYTE_EN = be;
    @(negedge Clk);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input int addr, output logic [31:0] dat);
    @(negedge Clk);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = 12'(addr);
    @(negedge Clk);
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    dat = avl.AVL_READDATA;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_rd;
  int          cnt;

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; cured = 1'b0;
    health_in[0] = 32'd5; health_in[1] = 32'd5;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    avl.AVL_ADDR = '0; avl.AVL_BYTE_EN = '0; avl.AVL_WRITEDATA = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state.
    check("rst_readdata", avl.AVL_READDATA, 32'h0);
    check("rst_to_cure", {30'b0, to_cure}, 32'h0);
    check("rst_game_run", {31'b0, game_run}, 32'h0);
    check("rst_game_attr", game_attr, 32'h0);
    check("rst_coin2", coin_attr[2], 32'h0);
    check("rst_init_pos0", init_pos[0], 32'h1);
    check("rst_init_pos1", init_pos[1], 32'h1);
    check("rst_wall15", wall_pos[15], 32'h0);
    for (int o = 0; o < 26; o++) begin
      avl_read(BASE + o, rd);
      exp_rd = (o == 7 || o == 8) ? 32'h1 : 32'h0;
      check($sformatf("rst_read_off%0d", o), rd, exp_rd);
    end

    // Byte-enabled shadow write, then commit at a tick.
    avl_write(BASE + 9 + 3, 32'h0001_4A2B, 4'b0011);
    avl_read(BASE + 12, rd);
    check("wall3_shadow", rd, 32'h0000_4A2B);
    check("wall3_live_pre", wall_pos[3], 32'h0);
    avl_write(BASE + 0, 32'h2, 4'hF);
    avl_read(BASE + 25, rd);
    check("status_pending", rd, 32'h1);
    check("wall3_live_still0", wall_pos[3], 32'h0);
    frame_tick = 1'b1;
    check("wall3_before_edge", wall_pos[3], 32'h0);
    @(negedge Clk);
    frame_tick = 1'b0;
    check("wall3_tick_clk", wall_pos[3], 32'h0000_4A2B);
    avl_read(BASE + 25, rd);
    check("status_cleared", rd, 32'h0);
    avl_read(BASE + 0, rd);
    check("ctrl_commit_raz", rd, 32'h0);

    // Commit write coincident with a tick: armed but not copied until the next tick.
    avl_write(BASE + 1, 32'h3, 4'hF);
    @(negedge Clk);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 12'(BASE);
    avl.AVL_WRITEDATA = 32'h3; avl.AVL_BYTE_EN = 4'hF; frame_tick = 1'b1;
    @(negedge Clk);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0; frame_tick = 1'b0;
    check("coinc_no_copy_run", {31'b0, game_run}, 32'h0);
    check("coinc_no_copy_attr", game_attr, 32'h0);
    avl_read(BASE + 25, rd);
    check("coinc_status", rd, 32'h1);
    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    check("coinc_copy_run", {31'b0, game_run}, 32'h1);
    check("coinc_copy_attr", game_attr, 32'h3);

    // Shadow write in the commit clock: live keeps the pre-write value.
    avl_write(BASE + 0, 32'h3, 4'hF);
    @(negedge Clk);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 12'(BASE + 1);
    avl.AVL_WRITEDATA = 32'h7; avl.AVL_BYTE_EN = 4'hF; frame_tick = 1'b1;
    @(negedge Clk);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0; frame_tick = 1'b0;
    check("race_live_old", game_attr, 32'h3);
    avl_read(BASE + 1, rd);
    check("race_shadow_new", rd, 32'h7);
    avl_write(BASE + 0, 32'h3, 4'hF);
    avl_write(BASE + 0, 32'h3, 4'hF);
    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    check("race_live_new", game_attr, 32'h7);
    avl_read(BASE + 25, rd);
    check("merged_commit_status", rd, 32'h0);

    // Cure handshake on tank 1.
    health_in[1] = 32'd3;
    avl_write(BASE + 6, 32'h1, 4'hF);
    check("cure1_assert", {30'b0, to_cure}, 32'h2);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (to_cure[1]) cnt++;
    end
    check("cure1_held100", cnt, 32'd100);
    avl_read(BASE + 25, rd);
    check("cure1_status_busy", rd, 32'h2);
    cured = 1'b1;
    @(negedge Clk);
    check("cure1_release", {30'b0, to_cure}, 32'h0);
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge Clk);
      if (to_cure[1]) cnt++;
    end
    check("cure1_no_reassert", cnt, 32'd0);
    cured = 1'b0;
    repeat (2) @(negedge Clk);
    avl_read(BASE + 25, rd);
    check("cure1_idle_status", rd, 32'h0);

    // Both tanks in REQ; one ack retires both.
    health_in[0] = 32'd1;
    avl_write(BASE + 5, 32'h1, 4'hF);
    avl_write(BASE + 6, 32'h1, 4'hF);
    check("cure_both_req", {30'b0, to_cure}, 32'h3);
    cured = 1'b1;
    @(negedge Clk);
    cured = 1'b0;
    check("cure_both_retired", {30'b0, to_cure}, 32'h0);
    repeat (2) @(negedge Clk);

    // Full health: no request.
    health_in[1] = 32'd5;
    avl_write(BASE + 6, 32'h1, 4'hF);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (to_cure[1]) cnt++;
      @(negedge Clk);
    end
    check("cure_full_never", cnt, 32'd0);
    avl_read(BASE + 25, rd);
    check("cure_full_status", rd, 32'h0);

    // Reset during a handshake.
    health_in[0] = 32'd2;
    avl_write(BASE + 5, 32'h1, 4'hF);
    check("cure0_assert", {30'b0, to_cure}, 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_mid_to_cure", {30'b0, to_cure}, 32'h0);
    check("rst_mid_game_attr", game_attr, 32'h0);
    avl_read(BASE + 25, rd);
    check("rst_mid_status", rd, 32'h0);
    repeat (3) @(negedge Clk);
    check("rst_mid_no_replay", {30'b0, to_cure}, 32'h0);
    avl_read(BASE + 7, rd);
    check("rst_init_read", rd, 32'h1);
    avl_read(BASE + 40, rd);
    check("oor_read", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
